// File: rtl/commu_m_pkg.sv
// Shared definitions for the master-path frame packer: state encoding,
// sync bytes and frame framing constants.
package commu_m_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_SEQ,
        ST_LEN,
        ST_PAY,
        ST_CHK,
        ST_DONE
    } state_t;

    localparam logic [7:0] HEAD0 = 8'hEB;
    localparam logic [7:0] HEAD1 = 8'h90;

    // Sync word (2) + sequence + length + checksum around the payload.
    localparam int FRAME_OVH = 5;

    // A programmed length of zero stands for a full 256-byte payload.
    function automatic logic [8:0] len_eff(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/commu_m_chk.sv
// 8-bit modulo-256 checksum accumulator with synchronous clear and add-enable.
module commu_m_chk (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] add_val,
    output logic [7:0] sum
);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sum <= 8'd0;
        end else if (clr) begin
            sum <= 8'd0;
        end else if (add_en) begin
            sum <= sum + add_val;
        end
    end

endmodule

// File: rtl/commu_m_frame.sv
// Frame packer: reads a payload from the source mux and emits
// sync word, sequence, length, payload and checksum byte-serially.
module commu_m_frame
    import commu_m_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       frm_start,
    input  logic [7:0] cfg_len,
    output logic       req_rd,
    input  logic [7:0] req_q,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    input  logic       tx_rdy,
    output logic       busy,
    output logic       frm_done,
    output logic [7:0] seq
);

    state_t     state;
    logic [7:0] len_r;
    logic [8:0] len_eff_r;
    logic [8:0] cnt;
    logic       pend;
    logic       slot_free;

    logic       chk_clr;
    logic       chk_add;
    logic [7:0] chk_val;
    logic [7:0] chk_sum;

    // The output register can take a new byte if empty or being drained this edge.
    assign slot_free = !tx_vld || tx_rdy;
    assign len_eff_r = len_eff(len_r);

    // Combinational so the returned byte lands exactly one cycle after the strobe.
    assign req_rd = (state == ST_PAY) && slot_free && !pend && (cnt < len_eff_r);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        chk_clr = 1'b0;
        chk_add = 1'b0;
        chk_val = 8'd0;
        case (state)
            ST_IDLE: chk_clr = frm_start;
            ST_SEQ: begin
                chk_add = slot_free;
                chk_val = seq;
            end
            ST_LEN: begin
                chk_add = slot_free;
                chk_val = len_r;
            end
            ST_PAY: begin
                chk_add = pend;
                chk_val = req_q;
            end
            default: ;
        endcase
    end

    commu_m_chk u_chk (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (chk_clr),
        .add_en  (chk_add),
        .add_val (chk_val),
        .sum     (chk_sum)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_r    <= 8'd0;
            cnt      <= 9'd0;
            pend     <= 1'b0;
            tx_data  <= 8'd0;
            tx_vld   <= 1'b0;
            busy     <= 1'b0;
            frm_done <= 1'b0;
            seq      <= 8'd0;
        end else begin
            frm_done <= 1'b0;
            if (tx_vld && tx_rdy) begin
                tx_vld <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (frm_start) begin
                        len_r <= cfg_len;
                        cnt   <= 9'd0;
                        pend  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_H0;
                    end
                end
                ST_H0: begin
                    if (slot_free) begin
                        tx_data <= HEAD0;
                        tx_vld  <= 1'b1;
                        state   <= ST_H1;
                    end
                end
                ST_H1: begin
                    if (slot_free) begin
                        tx_data <= HEAD1;
                        tx_vld  <= 1'b1;
                        state   <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (slot_free) begin
                        tx_data <= seq;
                        tx_vld  <= 1'b1;
                        state   <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (slot_free) begin
                        tx_data <= len_r;
                        tx_vld  <= 1'b1;
                        state   <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    // A read is only issued with a free slot, so the slot is empty when its data returns.
                    if (pend) begin
                        tx_data <= req_q;
                        tx_vld  <= 1'b1;
                        cnt     <= cnt + 9'd1;
                        pend    <= 1'b0;
                    end else if (req_rd) begin
                        pend <= 1'b1;
                    end else if (cnt == len_eff_r) begin
                        state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (slot_free) begin
                        tx_data <= chk_sum;
                        tx_vld  <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (tx_vld && tx_rdy) begin
                        frm_done <= 1'b1;
                        seq      <= seq + 8'd1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commu_m_frame.sv
// Self-checking bench for commu_m_frame: frame-level model with a byte
// scoreboard, source mux model, and directed scenarios.
module tb_commu_m_frame;
    import commu_m_pkg::*;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       frm_start = 1'b0;
    logic [7:0] cfg_len = 8'd0;
    logic       req_rd;
    logic [7:0] req_q = 8'd0;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy = 1'b1;
    logic       busy;
    logic       frm_done;
    logic [7:0] seq;

    always #5 clk_sys = ~clk_sys;

    commu_m_frame dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .frm_start (frm_start),
        .cfg_len   (cfg_len),
        .req_rd    (req_rd),
        .req_q     (req_q),
        .tx_data   (tx_data),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy),
        .busy      (busy),
        .frm_done  (frm_done),
        .seq       (seq)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         reads = 0;
    int         src_idx = 0;
    bit         rdy_rand = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'd0;
    logic [7:0] m_seq = 8'd0;
    logic [7:0] src_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] tx_log [$];
    logic [7:0] basic_exp [9] = '{8'hEB, 8'h90, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter readiness changes just after the edge.
    always @(posedge clk_sys) begin
        #2;
        tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Source mux: a strobe seen this cycle yields the next byte for the following cycle.
    always @(negedge clk_sys) begin
        if (!rst && req_rd) begin
            req_q = src_mem[src_idx % 256];
            src_idx++;
            reads++;
        end
    end

    // Scoreboard: every accepted byte must be the next one the model predicts.
    always @(negedge clk_sys) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (frm_done) done_cnt++;
            if (stall_prev) begin
                check("stall_vld_hold", tx_vld, 1'b1);
                check("stall_data_hold", tx_data, stall_data);
            end
            if (tx_vld && tx_rdy) begin
                check("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
                tx_log.push_back(tx_data);
            end
            stall_prev = tx_vld && !tx_rdy;
            stall_data = tx_data;
        end
    end

    task automatic expect_frame(input logic [7:0] len);
        int         n;
        logic [7:0] sum;
        n   = (len == 8'd0) ? 256 : int'(len);
        sum = m_seq + len;
        exp_q.push_back(HEAD0);
        exp_q.push_back(HEAD1);
        exp_q.push_back(m_seq);
        exp_q.push_back(len);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(src_mem[i]);
            sum += src_mem[i];
        end
        exp_q.push_back(sum);
    endtask

    task automatic pulse_start(input logic [7:0] len);
        cfg_len = len;
        @(posedge clk_sys);
        #2 frm_start = 1'b1;
        @(posedge clk_sys);
        #2 frm_start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] len, input bit rnd);
        int         n;
        int         d0;
        int         cyc;
        logic [7:0] nxt;
        n        = (len == 8'd0) ? 256 : int'(len);
        rdy_rand = rnd;
        src_idx  = 0;
        reads    = 0;
        tx_log.delete();
        expect_frame(len);
        d0 = done_cnt;
        pulse_start(len);
        check("busy_after_start", busy, 1'b1);
        cyc = 0;
        while (done_cnt == d0 && cyc < 20 * n + 100) begin
            @(negedge clk_sys);
            #1;
            cyc++;
        end
        nxt = m_seq + 8'd1;
        check("frm_done_once", done_cnt - d0, 1);
        check("read_count", reads, n);
        check("bytes_on_wire", tx_log.size(), n + FRAME_OVH);
        check("scoreboard_drained", exp_q.size(), 0);
        check("seq_next", seq, nxt);
        m_seq = nxt;
        exp_q.delete();
        @(negedge clk_sys);
        #1;
        check("busy_idle", busy, 1'b0);
        rdy_rand = 1'b0;
    endtask

    initial begin
        int d0;
        int r0;
        int cyc;
        bit was_ff;
        bit was_00;

        // Reset values
        repeat (2) @(posedge clk_sys);
        #2;
        check("rst_req_rd", req_rd, 1'b0);
        check("rst_tx_data", tx_data, 8'd0);
        check("rst_tx_vld", tx_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frm_done", frm_done, 1'b0);
        check("rst_seq", seq, 8'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk_sys);

        // Basic 4-byte frame, transmitter always ready
        for (int i = 0; i < 4; i++) src_mem[i] = 8'(i + 1);
        run_frame(8'd4, 1'b0);
        if (tx_log.size() == 9) begin
            for (int i = 0; i < 9; i++) check("basic_literal_byte", tx_log[i], basic_exp[i]);
        end
        check("basic_seq_after", seq, 8'd1);

        // Idle reset returns seq to zero
        @(posedge clk_sys);
        #3 rst = 1'b1;
        #2 check("idle_rst_seq", seq, 8'd0);
        @(posedge clk_sys);
        #2 rst = 1'b0;
        m_seq = 8'd0;

        // Asynchronous reset in the middle of the payload
        for (int i = 0; i < 8; i++) src_mem[i] = 8'(8'h30 + i);
        src_idx = 0;
        reads   = 0;
        expect_frame(8'd8);
        pulse_start(8'd8);
        cyc = 0;
        while (reads < 3 && cyc < 100) begin
            @(negedge clk_sys);
            #1;
            cyc++;
        end
        check("pay_reached", reads >= 3, 1'b1);
        @(posedge clk_sys);
        #3 rst = 1'b1;
        #1;
        check("abort_tx_vld", tx_vld, 1'b0);
        check("abort_tx_data", tx_data, 8'd0);
        check("abort_req_rd", req_rd, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_frm_done", frm_done, 1'b0);
        check("abort_seq", seq, 8'd0);
        exp_q.delete();
        r0 = reads;
        d0 = done_cnt;
        repeat (3) @(posedge clk_sys);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk_sys);
        #1;
        check("abort_no_more_reads", reads, r0);
        check("abort_no_done", done_cnt, d0);
        check("abort_still_idle", busy, 1'b0);

        // Length zero means 256 payload bytes, incrementing source
        for (int i = 0; i < 256; i++) src_mem[i] = 8'(i);
        run_frame(8'd0, 1'b0);
        if (tx_log.size() == 261) begin
            check("len0_len_byte", tx_log[3], 8'h00);
            check("len0_checksum", tx_log[260], 8'h80);
        end

        // Random backpressure over an 8-byte frame
        for (int i = 0; i < 8; i++) src_mem[i] = 8'($urandom_range(0, 255));
        run_frame(8'd8, 1'b1);

        // Start while busy and on the final accept cycle are both ignored
        for (int i = 0; i < 4; i++) src_mem[i] = 8'(8'hA0 + i);
        src_idx = 0;
        reads   = 0;
        expect_frame(8'd4);
        d0 = done_cnt;
        pulse_start(8'd4);
        repeat (3) @(posedge clk_sys);
        #2 frm_start = 1'b1;
        @(posedge clk_sys);
        #2 frm_start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk_sys);
            #1;
            cyc++;
            if (tx_vld && tx_rdy && exp_q.size() == 0) begin
                frm_start = 1'b1;
                @(posedge clk_sys);
                #2 frm_start = 1'b0;
                break;
            end
        end
        check("final_accept_seen", cyc < 200, 1'b1);
        repeat (30) @(negedge clk_sys);
        #1;
        check("ignored_single_done", done_cnt - d0, 1);
        check("ignored_reads", reads, 4);
        check("ignored_busy_low", busy, 1'b0);
        check("ignored_seq", seq, 8'(m_seq + 8'd1));
        m_seq = m_seq + 8'd1;

        // Sequence wrap over 257 one-byte frames
        for (int f = 0; f < 257; f++) begin
            src_mem[0] = 8'(f);
            was_ff = (m_seq == 8'hFF);
            was_00 = (m_seq == 8'h00);
            run_frame(8'd1, 1'b0);
            if (was_ff) begin
                check("wrap_seq_byte_ff", tx_log[2], 8'hFF);
                check("wrap_seq_reg_zero", seq, 8'd0);
            end
            if (was_00 && f > 0) check("wrap_seq_byte_00", tx_log[2], 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
